// File: rtl/freq_counter.sv
// Gated frequency counter: counts synchronized sig_in rises over GATE_CYCLES clk cycles.
// Define FREQ_COUNTER_OVF_EN for a saturating edge counter with a sticky overflow flag.
module freq_counter #(
  parameter int unsigned GATE_CYCLES = 50000000,
  parameter int unsigned CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             Fstart,
  output logic             Fbusy,
  input  logic             sig_in,
  output logic [CNT_W-1:0] freq,
  output logic             ovf
);

  // state | meaning
  // IDLE  | waiting for Fstart, last result held on freq/ovf
  // GATE  | counting rises for GATE_CYCLES cycles
  // DONE  | one cycle: publish result, drop Fbusy
  typedef enum logic [1:0] {IDLE, GATE, DONE} state_t;

  localparam logic [31:0] GATE_LAST = 32'(GATE_CYCLES - 1);

  state_t           state;
  logic             sync1, sync2, hist;
  logic             rise;
  logic [CNT_W-1:0] edge_cnt;
  logic [31:0]      gate_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      hist  <= 1'b0;
    end else begin
      sync1 <= sig_in;
      sync2 <= sync1;
      hist  <= sync2;
    end
  end

  assign rise = sync2 & ~hist;

`ifdef FREQ_COUNTER_OVF_EN
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  logic ovf_st;
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      Fbusy    <= 1'b0;
      freq     <= '0;
      edge_cnt <= '0;
      gate_cnt <= '0;
`ifdef FREQ_COUNTER_OVF_EN
      ovf      <= 1'b0;
      ovf_st   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (Fstart) begin
            state    <= GATE;
            Fbusy    <= 1'b1;
            edge_cnt <= '0;
            gate_cnt <= '0;
`ifdef FREQ_COUNTER_OVF_EN
            ovf_st   <= 1'b0;
`endif
          end
        end
        GATE: begin
          gate_cnt <= gate_cnt + 32'd1;
          if (rise) begin
`ifdef FREQ_COUNTER_OVF_EN
            // saturate and remember that at least one rise was lost
            if (edge_cnt == CNT_MAX) ovf_st <= 1'b1;
            else                     edge_cnt <= edge_cnt + CNT_W'(1);
`else
            edge_cnt <= edge_cnt + CNT_W'(1);
`endif
          end
          if (gate_cnt == GATE_LAST) state <= DONE;
        end
        DONE: begin
          freq  <= edge_cnt;
`ifdef FREQ_COUNTER_OVF_EN
          ovf   <= ovf_st;
`endif
          Fbusy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
